// File: rtl/logic4_arbiter_if.sv
// Request/response bundle for the shared 4-bit logic unit.
// The two requester channels and the single response channel live here; clk/rst_n stay separate ports.
interface logic4_arbiter_if #(
    parameter int WIDTH = 4
);
    logic             req0_valid;
    logic             req0_ready;
    logic [1:0]       req0_op;
    logic [WIDTH-1:0] req0_x;
    logic [WIDTH-1:0] req0_y;

    logic             req1_valid;
    logic             req1_ready;
    logic [1:0]       req1_op;
    logic [WIDTH-1:0] req1_x;
    logic [WIDTH-1:0] req1_y;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_data;
    logic             busy;

    // Requesters and the response consumer.
    modport master (
        output req0_valid, req0_op, req0_x, req0_y,
        input  req0_ready,
        output req1_valid, req1_op, req1_x, req1_y,
        input  req1_ready,
        input  rsp_valid, rsp_id, rsp_data, busy,
        output rsp_ready
    );

    // The arbiter itself.
    modport slave (
        input  req0_valid, req0_op, req0_x, req0_y,
        output req0_ready,
        input  req1_valid, req1_op, req1_x, req1_y,
        output req1_ready,
        output rsp_valid, rsp_id, rsp_data, busy,
        input  rsp_ready
    );
endinterface

// File: rtl/logic4_arbiter.sv
// Round-robin arbiter sharing one bitwise logic unit (AND/OR/NOR/XOR) between two requesters.
// IDLE accepts one op, EXEC holds it for EXEC_CYCLES, RESP presents the result until taken.
module logic4_arbiter #(
    parameter int WIDTH       = 4,
    parameter int EXEC_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    logic4_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_last_grant;
    logic [3:0]       r_cnt;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic             r_id;
    logic             r_rsp_valid;
    logic             r_rsp_id;
    logic [WIDTH-1:0] r_rsp_data;

    logic             w_req_any;
    logic             w_grant_id;
    logic             w_accept;
    logic             w_rsp_fire;

    function automatic logic [WIDTH-1:0] f_logic(input logic [1:0] op,
                                                 input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] res;
        case (op)
            2'b00:   res = x & y;
            2'b01:   res = x | y;
            2'b10:   res = ~(x | y);
            default: res = x ^ y;
        endcase
        return res;
    endfunction

    // A lone requester always wins; a tie goes to whoever was not served last.
    assign w_req_any  = bus.req0_valid | bus.req1_valid;
    assign w_grant_id = (bus.req0_valid & bus.req1_valid) ? ~r_last_grant : bus.req1_valid;
    assign w_accept   = (r_state == S_IDLE) & w_req_any;
    assign w_rsp_fire = (r_state == S_RESP) & bus.rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_nxt    = r_state;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Gated by rst_n so ready reads 0 while reset is held, even with valid high.
                bus.req0_ready = rst_n & w_req_any & ~w_grant_id;
                bus.req1_ready = rst_n & w_req_any &  w_grant_id;
                if (w_req_any) w_state_nxt = S_EXEC;
            end
            S_EXEC:  if (r_cnt == 4'd0) w_state_nxt = S_RESP;
            S_RESP:  if (bus.rsp_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: state is updated with <= so every flop samples pre-edge values, independent of block order.
    // NOTE: the captured operands are reset as well; they are a handful of flops, not a memory array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
            r_cnt        <= 4'd0;
            r_op         <= 2'b00;
            r_x          <= '0;
            r_y          <= '0;
            r_id         <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_data   <= '0;
        end else begin
            if (w_accept) begin
                r_op  <= w_grant_id ? bus.req1_op : bus.req0_op;
                r_x   <= w_grant_id ? bus.req1_x  : bus.req0_x;
                r_y   <= w_grant_id ? bus.req1_y  : bus.req0_y;
                r_id  <= w_grant_id;
                r_cnt <= CNT_LOAD;
            end
            if (r_state == S_EXEC) begin
                if (r_cnt != 4'd0) begin
                    r_cnt <= r_cnt - 4'd1;
                end else begin
                    r_rsp_data  <= f_logic(r_op, r_x, r_y);
                    r_rsp_id    <= r_id;
                    r_rsp_valid <= 1'b1;
                end
            end
            if (w_rsp_fire) begin
                r_rsp_valid  <= 1'b0;
                r_last_grant <= r_rsp_id;
            end
        end
    end

    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_logic4_arbiter.sv
// Directed bench for logic4_arbiter: a vector table for the op/requester matrix plus
// hand-written reset, fairness, backpressure and EXEC_CYCLES=3 latency sequences.
module tb_logic4_arbiter;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    logic4_arbiter_if #(.WIDTH(4)) a_if ();
    logic4_arbiter_if #(.WIDTH(4)) b_if ();

    logic4_arbiter #(.WIDTH(4), .EXEC_CYCLES(1)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (a_if.slave)
    );

    logic4_arbiter #(.WIDTH(4), .EXEC_CYCLES(3)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic       id;
        logic [1:0] op;
        logic [3:0] x;
        logic [3:0] y;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One complete transaction on DUT A with rsp_ready held high; entered #1 after a posedge.
    task automatic run_op(input logic id, input logic [1:0] op, input logic [3:0] x,
                          input logic [3:0] y, input logic [3:0] exp, input string name);
        int n;
        a_if.rsp_ready = 1'b1;
        if (id) begin
            a_if.req1_valid = 1'b1; a_if.req1_op = op; a_if.req1_x = x; a_if.req1_y = y;
        end else begin
            a_if.req0_valid = 1'b1; a_if.req0_op = op; a_if.req0_x = x; a_if.req0_y = y;
        end
        n = 0;
        @(negedge clk);
        while (!(id ? a_if.req1_ready : a_if.req0_ready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, "_ready"}, {7'd0, id ? a_if.req1_ready : a_if.req0_ready}, 8'd1);
        @(posedge clk);
        #1;
        a_if.req0_valid = 1'b0;
        a_if.req1_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!a_if.rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, "_valid"}, {7'd0, a_if.rsp_valid}, 8'd1);
        check({name, "_data"},  {4'd0, a_if.rsp_data}, {4'd0, exp});
        check({name, "_id"},    {7'd0, a_if.rsp_id}, {7'd0, id});
        @(posedge clk);
        #1;
        @(negedge clk);
        check({name, "_idle"}, {6'd0, a_if.busy, a_if.rsp_valid}, 8'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int acc[2];

        vecs[0] = '{1'b0, 2'b10, 4'b0000, 4'b0000, 4'b1111};
        vecs[1] = '{1'b0, 2'b10, 4'b0000, 4'b0001, 4'b1110};
        vecs[2] = '{1'b0, 2'b10, 4'b0001, 4'b0000, 4'b1110};
        vecs[3] = '{1'b0, 2'b10, 4'b0001, 4'b0001, 4'b1110};
        vecs[4] = '{1'b1, 2'b00, 4'b1100, 4'b1010, 4'b1000};
        vecs[5] = '{1'b1, 2'b01, 4'b1100, 4'b1010, 4'b1110};
        vecs[6] = '{1'b1, 2'b11, 4'b1100, 4'b1010, 4'b0110};

        rst_n = 1'b0;
        a_if.req0_valid = 1'b0; a_if.req0_op = 2'b00; a_if.req0_x = 4'd0; a_if.req0_y = 4'd0;
        a_if.req1_valid = 1'b0; a_if.req1_op = 2'b00; a_if.req1_x = 4'd0; a_if.req1_y = 4'd0;
        a_if.rsp_ready  = 1'b0;
        b_if.req0_valid = 1'b0; b_if.req0_op = 2'b00; b_if.req0_x = 4'd0; b_if.req0_y = 4'd0;
        b_if.req1_valid = 1'b0; b_if.req1_op = 2'b00; b_if.req1_x = 4'd0; b_if.req1_y = 4'd0;
        b_if.rsp_ready  = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", {7'd0, a_if.rsp_valid}, 8'd0);
        check("rst_busy",  {7'd0, a_if.busy}, 8'd0);
        check("rst_data",  {3'd0, a_if.rsp_id, a_if.rsp_data}, 8'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset asserted mid-EXEC drops the op and clears outputs immediately.
        a_if.req0_valid = 1'b1; a_if.req0_op = 2'b00; a_if.req0_x = 4'hF; a_if.req0_y = 4'hF;
        a_if.rsp_ready  = 1'b1;
        @(negedge clk);
        check("rst_pre_ready", {7'd0, a_if.req0_ready}, 8'd1);
        @(posedge clk);
        #1;
        check("rst_pre_busy", {7'd0, a_if.busy}, 8'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy",  {7'd0, a_if.busy}, 8'd0);
        check("rst_mid_valid", {7'd0, a_if.rsp_valid}, 8'd0);
        check("rst_mid_ready", {6'd0, a_if.req1_ready, a_if.req0_ready}, 8'd0);
        @(posedge clk);
        @(negedge clk);
        check("rst_drop_valid", {7'd0, a_if.rsp_valid}, 8'd0);
        a_if.req0_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // NOR truth table via requester 0, then AND/OR/XOR via requester 1.
        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].id, vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].exp,
                   $sformatf("vec%0d", i));
        end

        // Both valid continuously: grants alternate 0,1,0,1.
        @(posedge clk);
        #1;
        a_if.rsp_ready  = 1'b1;
        a_if.req0_valid = 1'b1; a_if.req0_op = 2'b00; a_if.req0_x = 4'b1111; a_if.req0_y = 4'b0101;
        a_if.req1_valid = 1'b1; a_if.req1_op = 2'b01; a_if.req1_x = 4'b0001; a_if.req1_y = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            @(negedge clk);
            while (!(a_if.req0_ready | a_if.req1_ready) && n < 20) begin
                @(negedge clk);
                n++;
            end
            check($sformatf("fair%0d_grant", i), {6'd0, a_if.req1_ready, a_if.req0_ready},
                  (i % 2 == 1) ? 8'd2 : 8'd1);
            @(posedge clk);
            #1;
            @(negedge clk);
            check($sformatf("fair%0d_exec_ready", i), {6'd0, a_if.req1_ready, a_if.req0_ready}, 8'd0);
            n = 0;
            while (!a_if.rsp_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            check($sformatf("fair%0d_resp_ready", i), {6'd0, a_if.req1_ready, a_if.req0_ready}, 8'd0);
            check($sformatf("fair%0d_id", i), {7'd0, a_if.rsp_id}, (i % 2 == 1) ? 8'd1 : 8'd0);
            check($sformatf("fair%0d_data", i), {4'd0, a_if.rsp_data},
                  (i % 2 == 1) ? 8'b0000_0011 : 8'b0000_0101);
            @(posedge clk);
            #1;
        end
        a_if.req0_valid = 1'b0;
        a_if.req1_valid = 1'b0;

        // Backpressure: result held for 5 cycles, no new acceptance while busy.
        @(posedge clk);
        #1;
        a_if.rsp_ready  = 1'b0;
        a_if.req0_valid = 1'b1; a_if.req0_op = 2'b11; a_if.req0_x = 4'b1010; a_if.req0_y = 4'b0110;
        @(negedge clk);
        check("bp_accept", {7'd0, a_if.req0_ready}, 8'd1);
        @(posedge clk);
        #1;
        a_if.req0_valid = 1'b0;
        a_if.req1_valid = 1'b1; a_if.req1_op = 2'b00; a_if.req1_x = 4'b0011; a_if.req1_y = 4'b0110;
        n = 0;
        @(negedge clk);
        while (!a_if.rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp%0d_valid", i), {7'd0, a_if.rsp_valid}, 8'd1);
            check($sformatf("bp%0d_data", i), {3'd0, a_if.rsp_id, a_if.rsp_data}, 8'b0000_1100);
            check($sformatf("bp%0d_busy", i), {7'd0, a_if.busy}, 8'd1);
            check($sformatf("bp%0d_ready", i), {6'd0, a_if.req1_ready, a_if.req0_ready}, 8'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        a_if.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_release_idle", {6'd0, a_if.busy, a_if.rsp_valid}, 8'd0);
        check("bp_release_ready", {6'd0, a_if.req1_ready, a_if.req0_ready}, 8'd2);
        @(posedge clk);
        #1;
        a_if.req1_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!a_if.rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bp_next_data", {3'd0, a_if.rsp_id, a_if.rsp_data}, 8'b0001_0010);
        @(posedge clk);
        #1;

        // EXEC_CYCLES=3: latency of 3 edges and an issue interval of 5 cycles.
        b_if.rsp_ready  = 1'b1;
        b_if.req0_valid = 1'b1; b_if.req0_op = 2'b10; b_if.req0_x = 4'b0101; b_if.req0_y = 4'b0011;
        for (int k = 0; k < 2; k++) begin
            n = 0;
            @(negedge clk);
            while (!b_if.req0_ready && n < 20) begin
                @(negedge clk);
                n++;
            end
            check($sformatf("e3_%0d_ready", k), {7'd0, b_if.req0_ready}, 8'd1);
            @(posedge clk);
            #1;
            acc[k] = cyc;
            for (int j = 1; j <= 3; j++) begin
                @(posedge clk);
                @(negedge clk);
                check($sformatf("e3_%0d_lat%0d", k, j), {7'd0, b_if.rsp_valid}, (j == 3) ? 8'd1 : 8'd0);
                check($sformatf("e3_%0d_rdy%0d", k, j), {7'd0, b_if.req0_ready}, 8'd0);
            end
            check($sformatf("e3_%0d_data", k), {3'd0, b_if.rsp_id, b_if.rsp_data}, 8'b0000_1000);
        end
        b_if.req0_valid = 1'b0;
        check("e3_interval", 8'(acc[1] - acc[0]), 8'd5);
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
